// File: rtl/display_mux_7seg_if.sv
// Bus between a display controller and display_mux_7seg: digit data, pacing tick and the multiplexed drive outputs.
// tick_src is a free-running pacing clock sampled as data: each rising edge advances one digit. There is no valid/ready handshake.
interface display_mux_7seg_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    tick_src;
    logic                    enable;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic [2:0]              dbg_idx;

    modport master (
        output tick_src, enable, value, dp_mask,
        input  an, seg, dp, dbg_idx
    );

    modport slave (
        input  tick_src, enable, value, dp_mask,
        output an, seg, dp, dbg_idx
    );
endinterface

// File: rtl/display_mux_7seg.sv
// Time-multiplexed 7-segment driver: one digit per tick_src rising edge, frame-coherent shadow data.
// Optional leading-zero blanking is built when the macro LEADING_ZERO_BLANK_EN is defined.
module display_mux_7seg #(
    parameter int NUM_DIGITS = 8
) (
    input  logic              clk_in,
    input  logic              reset,
    display_mux_7seg_if.slave bus
);
    localparam int               IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic                    s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] val_sh_q, val_sh_d;
    logic [NUM_DIGITS-1:0]   dpm_sh_q, dpm_sh_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    strobe;
    logic                    shown;
    logic [3:0]              cur_nib;

    // Active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msd;

    // Most significant nonzero shadow nibble; digit 0 always counts as significant.
    always_comb begin
        msd = '0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (val_sh_q[4*k +: 4] != 4'h0) msd = IDX_W'(k);
        end
    end

    assign shown = (idx_q <= msd);
`else
    assign shown = 1'b1;
`endif

    always_comb begin
        s1_d     = bus.tick_src;
        s2_d     = s1_q;
        s3_d     = s2_q;
        strobe   = s2_q & ~s3_q;
        idx_d    = idx_q;
        val_sh_d = val_sh_q;
        dpm_sh_d = dpm_sh_q;
        // Strobes while disabled are consumed by s3 and simply lost.
        if (strobe && bus.enable) begin
            if (idx_q == LAST_IDX) begin
                idx_d    = '0;
                val_sh_d = bus.value;
                dpm_sh_d = bus.dp_mask;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        cur_nib = val_sh_q[4*idx_q +: 4];
        an_d    = '1;
        seg_d   = 7'h7F;
        dp_d    = 1'b1;
        if (bus.enable && shown) begin
            an_d[idx_q] = 1'b0;
            seg_d       = hex7(cur_nib);
            dp_d        = ~dpm_sh_q[idx_q];
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            idx_q    <= '0;
            val_sh_q <= '0;
            dpm_sh_q <= '0;
            an_q     <= '1;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            idx_q    <= idx_d;
            val_sh_q <= val_sh_d;
            dpm_sh_q <= dpm_sh_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign bus.an      = an_q;
    assign bus.seg     = seg_q;
    assign bus.dp      = dp_q;
    assign bus.dbg_idx = 3'(idx_q);
endmodule

// File: tb/tb_display_mux_7seg.sv
// Directed bench for display_mux_7seg with a per-cycle behavioural model and hand-computed checkpoints.
// Build with +define+LEADING_ZERO_BLANK_EN to exercise the blanking variant.
module tb_display_mux_7seg;
  localparam int N = 8;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  int   n_vec  = 0;
  int   n_err  = 0;

  display_mux_7seg_if #(.NUM_DIGITS(N)) bus ();

  display_mux_7seg #(.NUM_DIGITS(N)) dut (
    .clk_in(clk_in),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[n];
  endfunction

  // Model: a tick first seen high at edge n (after being seen low) advances the digit at edge n+2;
  // the display seen after edge n shows the digit selected before edge n.
  int          m_idx = 0;
  logic [31:0] m_val = '0;
  logic [7:0]  m_dpm = '0;
  bit          m_prev = 1'b0;
  int          sched[$];
  int          edge_n = 0;
  logic [7:0]  e_an = 8'hFF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;

  always @(posedge clk_in) begin
    bit          t, en, shown;
    logic [31:0] v;
    logic [7:0]  m;
    int          msd;
    t  = bus.tick_src;
    en = bus.enable;
    v  = bus.value;
    m  = bus.dp_mask;
    if (reset) begin
      m_idx  = 0;
      m_val  = '0;
      m_dpm  = '0;
      m_prev = 1'b0;
      sched.delete();
      e_an   = 8'hFF;
      e_seg  = 7'h7F;
      e_dp   = 1'b1;
    end else begin
      msd = 0;
      for (int k = 1; k < N; k++) if (m_val[4*k +: 4] != 4'h0) msd = k;
      shown = !BLANK || (m_idx <= msd);
      if (en && shown) begin
        e_an  = ~(8'd1 << m_idx);
        e_seg = hex7(m_val[4*m_idx +: 4]);
        e_dp  = ~m_dpm[m_idx];
      end else begin
        e_an  = 8'hFF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
      end
      if (sched.size() > 0 && sched[0] == edge_n) begin
        void'(sched.pop_front());
        if (en) begin
          m_idx = (m_idx + 1) % N;
          if (m_idx == 0) begin
            m_val = v;
            m_dpm = m;
          end
        end
      end
      if (t && !m_prev) sched.push_back(edge_n + 2);
      m_prev = t;
    end
    edge_n++;
    #1;
    check("model_an", bus.an, e_an);
    check("model_seg", bus.seg, e_seg);
    check("model_dp", bus.dp, e_dp);
    check("model_idx", bus.dbg_idx, m_idx);
  end

  task automatic tick();
    @(negedge clk_in);
    bus.tick_src = 1'b1;
    repeat (3) @(negedge clk_in);
    bus.tick_src = 1'b0;
    repeat (3) @(negedge clk_in);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_an;
    logic [6:0] f_seg [8];
    bit         shown_k;
    bus.tick_src = 1'b0;
    bus.enable   = 1'b1;
    bus.value    = 32'h89ABCDEF;
    bus.dp_mask  = 8'h01;

    repeat (3) @(negedge clk_in);
    check("reset_an", bus.an, 8'hFF);
    check("reset_seg", bus.seg, 7'h7F);
    check("reset_dp", bus.dp, 1'b1);
    check("reset_idx", bus.dbg_idx, 3'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk_in);
    check("idle_an", bus.an, 8'hFE);
    check("idle_seg_zero_shadow", bus.seg, 7'b1000000);

    // Eight ticks walk the anodes and wrap, loading the shadows.
    tick();
    check("walk1_an", bus.an, 8'hFD);
    check("walk1_dp", bus.dp, 1'b1);
    repeat (6) tick();
    check("walk7_an", bus.an, 8'h7F);
    tick();
    check("wrap_an", bus.an, 8'hFE);
    check("wrap_seg_F", bus.seg, 7'b0001110);
    check("wrap_dp", bus.dp, 1'b0);

    // Single tick: outputs move on edge 4 only.
    @(negedge clk_in);
    bus.tick_src = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk_in);
      #1;
      if (e < 4) begin
        check("edge_an_before", bus.an, 8'hFE);
        check("edge_seg_before", bus.seg, 7'b0001110);
      end else begin
        check("edge_an_after", bus.an, 8'hFD);
        check("edge_seg_after", bus.seg, 7'b0000110);
      end
    end
    @(negedge clk_in);
    bus.tick_src = 1'b0;
    repeat (3) @(negedge clk_in);
    check("edge_an_settled", bus.an, 8'hFD);

    // Frame coherence: a mid-frame value change waits for the wrap.
    bus.value = 32'h00000000;
    repeat (7) tick();
    check("zero_frame_seg", bus.seg, 7'b1000000);
    bus.value = 32'h11111111;
    tick();
    check("midframe_seg_still0", bus.seg, 7'b1000000);
    check("midframe_an", bus.an, 8'hFD);
    repeat (7) tick();
    check("newframe_seg0", bus.seg, 7'b1111001);
    tick();
    check("newframe_seg1", bus.seg, 7'b1111001);

    // Disable at idx 3, tick while disabled, re-enable.
    repeat (2) tick();
    check("pre_dis_idx", bus.dbg_idx, 3'd3);
    check("pre_dis_an", bus.an, 8'hF7);
    @(negedge clk_in);
    bus.enable = 1'b0;
    @(posedge clk_in);
    #1;
    check("dis_an", bus.an, 8'hFF);
    check("dis_seg", bus.seg, 7'h7F);
    check("dis_dp", bus.dp, 1'b1);
    repeat (5) tick();
    check("dis_hold_an", bus.an, 8'hFF);
    check("dis_hold_idx", bus.dbg_idx, 3'd3);
    @(negedge clk_in);
    bus.enable = 1'b1;
    @(posedge clk_in);
    #1;
    check("reen_an", bus.an, 8'hF7);
    check("reen_idx", bus.dbg_idx, 3'd3);
    tick();
    check("reen_tick_an", bus.an, 8'hEF);
    check("reen_tick_idx", bus.dbg_idx, 3'd4);

    // One-cycle reset at idx 5 with tick_src high.
    tick();
    check("pre_rst_idx", bus.dbg_idx, 3'd5);
    @(negedge clk_in);
    reset = 1'b1;
    bus.tick_src = 1'b1;
    @(posedge clk_in);
    #1;
    check("rst_an", bus.an, 8'hFF);
    check("rst_idx", bus.dbg_idx, 3'd0);
    @(negedge clk_in);
    reset = 1'b0;
    repeat (8) @(negedge clk_in);
    check("rst_one_strobe_idx", bus.dbg_idx, 3'd1);
    bus.tick_src = 1'b0;
    repeat (6) @(negedge clk_in);
    check("rst_no_extra_idx", bus.dbg_idx, 3'd1);
    check("rst_no_extra_an", bus.an, 8'hFD);

    // Leading zeros: blanked only in the blanking build.
    @(negedge clk_in);
    reset = 1'b1;
    bus.value = 32'h00000A05;
    bus.dp_mask = 8'hFF;
    @(negedge clk_in);
    reset = 1'b0;
    repeat (8) tick();
    f_seg = '{7'b0010010, 7'b1000000, 7'b0001000, 7'b1000000,
              7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
    for (int k = 0; k < N; k++) begin
      shown_k = !BLANK || (k <= 2);
      exp_an = shown_k ? ~(8'd1 << k) : 8'hFF;
      check("lzb_an", bus.an, exp_an);
      check("lzb_seg", bus.seg, shown_k ? f_seg[k] : 7'h7F);
      check("lzb_dp", bus.dp, shown_k ? 1'b0 : 1'b1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
